// File: rtl/cv32e40p_pkg.sv
// Shared definitions for the fault-tolerant EX stage: ALU opcodes, operator
// class indices, voter modes, reconfiguration FSM states and the operator to
// class mapping used by both the permanent-fault counters and the
// reconfiguration controller.
package cv32e40p_pkg;

  localparam int ALU_OP_WIDTH = 7;
  localparam int N_ALU_FT     = 4;
  localparam int N_CLASS_FT   = 9;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD   = 7'b0011000, ALU_SUB   = 7'b0011001, ALU_ADDU  = 7'b0011010,
    ALU_SUBU  = 7'b0011011, ALU_ADDR  = 7'b0011100, ALU_SUBR  = 7'b0011101,
    ALU_ADDUR = 7'b0011110, ALU_SUBUR = 7'b0011111,
    ALU_XOR   = 7'b0101111, ALU_OR    = 7'b0101110, ALU_AND   = 7'b0010101,
    ALU_SRA   = 7'b0100100, ALU_SRL   = 7'b0100101, ALU_ROR   = 7'b0100110,
    ALU_SLL   = 7'b0100111,
    ALU_BEXT  = 7'b0101000, ALU_BEXTU = 7'b0101001, ALU_BINS  = 7'b0101010,
    ALU_BCLR  = 7'b0101011, ALU_BSET  = 7'b0101100, ALU_BREV  = 7'b1001001,
    ALU_FF1   = 7'b0110110, ALU_FL1   = 7'b0110111, ALU_CNT   = 7'b0110100,
    ALU_CLB   = 7'b0110101,
    ALU_EXTS  = 7'b0111110, ALU_EXT   = 7'b0111111, ALU_INS   = 7'b0101101,
    ALU_SHUF  = 7'b0111010, ALU_SHUF2 = 7'b0111011, ALU_PCKLO = 7'b0111000,
    ALU_PCKHI = 7'b0111001,
    ALU_LTS   = 7'b0000000, ALU_LTU   = 7'b0000001, ALU_LES   = 7'b0000100,
    ALU_LEU   = 7'b0000101, ALU_GTS   = 7'b0001000, ALU_GTU   = 7'b0001001,
    ALU_GES   = 7'b0001010, ALU_GEU   = 7'b0001011, ALU_EQ    = 7'b0001100,
    ALU_NE    = 7'b0001101, ALU_SLTS  = 7'b0000010, ALU_SLTU  = 7'b0000011,
    ALU_SLETS = 7'b0000110, ALU_SLETU = 7'b0000111,
    ALU_ABS   = 7'b0010100, ALU_CLIP  = 7'b0010110, ALU_CLIPU = 7'b0010111,
    ALU_MIN   = 7'b0010000, ALU_MINU  = 7'b0010001, ALU_MAX   = 7'b0010010,
    ALU_MAXU  = 7'b0010011,
    ALU_DIVU  = 7'b0110000, ALU_DIV   = 7'b0110001, ALU_REMU  = 7'b0110010,
    ALU_REM   = 7'b0110011
  } alu_opcode_e;

  localparam logic [3:0] ALU_CLASS_SHIFT_ADD = 4'd0;
  localparam logic [3:0] ALU_CLASS_LOGIC     = 4'd1;
  localparam logic [3:0] ALU_CLASS_BITMAN    = 4'd2;
  localparam logic [3:0] ALU_CLASS_BITCNT    = 4'd3;
  localparam logic [3:0] ALU_CLASS_SHUFFLE   = 4'd4;
  localparam logic [3:0] ALU_CLASS_COMPARE   = 4'd5;
  localparam logic [3:0] ALU_CLASS_ABS_CLIP  = 4'd6;
  localparam logic [3:0] ALU_CLASS_MIN_MAX   = 4'd7;
  localparam logic [3:0] ALU_CLASS_DIV_REM   = 4'd8;
  localparam logic [3:0] ALU_CLASS_NONE      = 4'hF;

  typedef enum logic [1:0] {
    VOTE_TMR    = 2'd0,
    VOTE_DMR    = 2'd1,
    VOTE_SINGLE = 2'd2,
    VOTE_NONE   = 2'd3
  } vote_mode_e;

  typedef enum logic [1:0] {
    AR_RUN,
    AR_DRAIN,
    AR_REBUILD,
    AR_SETTLE
  } alu_reconfig_state_e;

  function automatic logic [3:0] alu_op_class(input logic [ALU_OP_WIDTH-1:0] op);
    logic [3:0] cls;
    case (op)
      ALU_ADD, ALU_SUB, ALU_ADDU, ALU_SUBU, ALU_ADDR, ALU_SUBR, ALU_ADDUR,
      ALU_SUBUR, ALU_SRA, ALU_SRL, ALU_ROR, ALU_SLL:
        cls = ALU_CLASS_SHIFT_ADD;
      ALU_XOR, ALU_OR, ALU_AND:
        cls = ALU_CLASS_LOGIC;
      ALU_BEXT, ALU_BEXTU, ALU_BINS, ALU_BCLR, ALU_BSET, ALU_BREV:
        cls = ALU_CLASS_BITMAN;
      ALU_FF1, ALU_FL1, ALU_CNT, ALU_CLB:
        cls = ALU_CLASS_BITCNT;
      ALU_EXTS, ALU_EXT, ALU_INS, ALU_SHUF, ALU_SHUF2, ALU_PCKLO, ALU_PCKHI:
        cls = ALU_CLASS_SHUFFLE;
      ALU_LTS, ALU_LTU, ALU_LES, ALU_LEU, ALU_GTS, ALU_GTU, ALU_GES, ALU_GEU,
      ALU_EQ, ALU_NE, ALU_SLTS, ALU_SLTU, ALU_SLETS, ALU_SLETU:
        cls = ALU_CLASS_COMPARE;
      ALU_ABS, ALU_CLIP, ALU_CLIPU:
        cls = ALU_CLASS_ABS_CLIP;
      ALU_MIN, ALU_MINU, ALU_MAX, ALU_MAXU:
        cls = ALU_CLASS_MIN_MAX;
      ALU_DIVU, ALU_DIV, ALU_REMU, ALU_REM:
        cls = ALU_CLASS_DIV_REM;
      default:
        cls = ALU_CLASS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/cv32e40p_alu_pick3.sv
// Picks the ALUs that serve one operator class.
//   healthy : bit a set when ALU a is usable for the class
//   mask    : the lowest-indexed (up to three) healthy ALUs
//   mode    : voter mode implied by how many ALUs were picked
module cv32e40p_alu_pick3
  import cv32e40p_pkg::*;
(
  input  logic [3:0] healthy,
  output logic [3:0] mask,
  output vote_mode_e mode
);

  logic [1:0] taken;

  always_comb begin
    mask  = '0;
    taken = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (healthy[i] && (taken != 2'd3)) begin
        mask[i] = 1'b1;
        taken   = taken + 2'd1;
      end
    end
  end

  always_comb begin
    case (taken)
      2'd3:    mode = VOTE_TMR;
      2'd2:    mode = VOTE_DMR;
      2'd1:    mode = VOTE_SINGLE;
      default: mode = VOTE_NONE;
    endcase
  end

endmodule

// File: rtl/cv32e40p_alu_reconfig_ft.sv
// ALU reconfiguration controller for the fault-tolerant EX stage. Keeps a
// per-class allocation table (ALU mask + voter mode) derived from the
// permanent-fault matrix and rebuilds it, with issue stalled, whenever the
// matrix changes.
//   clock_gated, rst_n      : clock, synchronous active-low reset
//   permanent_faulty_alu_i  : [alu][class] permanent fault flags
//   alu_en_i, alu_operator_i: operation being issued this cycle
//   pipe_empty_i            : no ALU operation in flight in EX
//   alu_en_o, vote_mode_o   : ALU enables / voter mode for the issued op
//   stall_o                 : hold issue in ID
//   cnt_clk_en_o            : clock enables for the fault counters
//   fatal_o                 : sticky, some class has no healthy ALU
module cv32e40p_alu_reconfig_ft
  import cv32e40p_pkg::*;
#(
  parameter int N_ALU   = N_ALU_FT,
  parameter int N_CLASS = N_CLASS_FT
) (
  input  logic                                clock_gated,
  input  logic                                rst_n,
  input  logic [N_ALU-1:0][N_CLASS-1:0]       permanent_faulty_alu_i,
  input  logic                                alu_en_i,
  input  logic [ALU_OP_WIDTH-1:0]             alu_operator_i,
  input  logic                                pipe_empty_i,
  output logic [N_ALU-1:0]                    alu_en_o,
  output logic [1:0]                          vote_mode_o,
  output logic                                stall_o,
  output logic [N_ALU-1:0]                    cnt_clk_en_o,
  output logic                                fatal_o
);

  alu_reconfig_state_e             state_q;
  logic [N_ALU-1:0][N_CLASS-1:0]   faulty_q;
  logic [3:0]                      idx_q;
  logic [N_ALU-1:0]                tbl_mask_q [N_CLASS];
  vote_mode_e                      tbl_mode_q [N_CLASS];

  logic                            change;
  logic [N_ALU-1:0]                healthy;
  logic [N_ALU-1:0]                pick_mask;
  vote_mode_e                      pick_mode;
  logic [N_ALU-1:0]                used_alus;
  logic [3:0]                      op_cls;
  logic                            cls_valid;
  logic [3:0]                      cls_idx;
  vote_mode_e                      cls_mode;

  assign change = (permanent_faulty_alu_i != faulty_q);

  // Column of the captured matrix selected by the rebuild index.
  always_comb begin
    healthy = '0;
    for (int unsigned a = 0; a < N_ALU; a++) begin
      healthy[a] = ~faulty_q[a][idx_q];
    end
  end

  cv32e40p_alu_pick3 u_pick3 (
    .healthy (healthy),
    .mask    (pick_mask),
    .mode    (pick_mode)
  );

  always_comb begin
    used_alus = '0;
    for (int unsigned c = 0; c < N_CLASS; c++) begin
      used_alus = used_alus | tbl_mask_q[c];
    end
  end

  always_ff @(posedge clock_gated) begin
    if (!rst_n) begin
      state_q      <= AR_RUN;
      faulty_q     <= '0;
      idx_q        <= '0;
      cnt_clk_en_o <= '1;
      fatal_o      <= 1'b0;
      for (int unsigned i = 0; i < N_CLASS; i++) begin
        tbl_mask_q[i] <= 4'b0111;
        tbl_mode_q[i] <= VOTE_TMR;
      end
    end else begin
      case (state_q)
        AR_RUN: begin
          if (change) state_q <= AR_DRAIN;
        end
        AR_DRAIN: begin
          // Matrix is captured at drain exit so late changes are included.
          if (pipe_empty_i) begin
            faulty_q <= permanent_faulty_alu_i;
            idx_q    <= '0;
            state_q  <= AR_REBUILD;
          end
        end
        AR_REBUILD: begin
          tbl_mask_q[idx_q] <= pick_mask;
          tbl_mode_q[idx_q] <= pick_mode;
          if (pick_mode == VOTE_NONE) fatal_o <= 1'b1;
          if (idx_q == 4'(N_CLASS - 1)) state_q <= AR_SETTLE;
          else                          idx_q   <= idx_q + 4'd1;
        end
        AR_SETTLE: begin
          // A change seen here arrived after the drain-exit capture.
          if (change) begin
            state_q <= AR_DRAIN;
          end else begin
            state_q      <= AR_RUN;
            cnt_clk_en_o <= used_alus;
          end
        end
        default: state_q <= AR_RUN;
      endcase
    end
  end

  assign op_cls    = alu_op_class(alu_operator_i);
  assign cls_valid = (op_cls != ALU_CLASS_NONE) && (op_cls < 4'(N_CLASS));
  assign cls_idx   = cls_valid ? op_cls : '0;
  assign cls_mode  = tbl_mode_q[cls_idx];

  // A pending change stalls in the detecting cycle itself.
  assign stall_o = (state_q != AR_RUN) || change;

  always_comb begin
    alu_en_o    = '0;
    vote_mode_o = cls_valid ? cls_mode : VOTE_TMR;
    if (!stall_o && alu_en_i && cls_valid && (cls_mode != VOTE_NONE)) begin
      alu_en_o = tbl_mask_q[cls_idx];
    end
  end

endmodule

// File: tb/tb_cv32e40p_alu_reconfig_ft.sv
module tb_cv32e40p_alu_reconfig_ft;
  import cv32e40p_pkg::*;

  logic             clock_gated = 1'b0;
  logic             rst_n;
  logic [3:0][8:0]  permanent_faulty_alu_i;
  logic             alu_en_i;
  logic [6:0]       alu_operator_i;
  logic             pipe_empty_i;
  logic [3:0]       alu_en_o;
  logic [1:0]       vote_mode_o;
  logic             stall_o;
  logic [3:0]       cnt_clk_en_o;
  logic             fatal_o;

  int checks = 0;
  int passed = 0;
  logic [3:0][8:0] faults;

  cv32e40p_alu_reconfig_ft #(.N_ALU(4), .N_CLASS(9)) dut (
    .clock_gated            (clock_gated),
    .rst_n                  (rst_n),
    .permanent_faulty_alu_i (permanent_faulty_alu_i),
    .alu_en_i               (alu_en_i),
    .alu_operator_i         (alu_operator_i),
    .pipe_empty_i           (pipe_empty_i),
    .alu_en_o               (alu_en_o),
    .vote_mode_o            (vote_mode_o),
    .stall_o                (stall_o),
    .cnt_clk_en_o           (cnt_clk_en_o),
    .fatal_o                (fatal_o)
  );

  always #5 clock_gated = ~clock_gated;

  // Present an op in a fresh cycle; outputs are read 1 ns later.
  task automatic issue(input logic [6:0] op);
    @(posedge clock_gated); #1;
    alu_en_i = 1'b1;
    alu_operator_i = op;
    #1;
  endtask

  // Called in the cycle where a change is first presented. Counts the
  // stalled cycles that follow it. pipe_empty_i is held low for the first
  // 'hold' of them; at cycle 'race_at' the fault input becomes race_f.
  task automatic count_stall(input int hold, input int race_at,
                             input logic [3:0][8:0] race_f, output int n);
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clock_gated); #1;
      pipe_empty_i = (k > hold);
      if (k == race_at) begin
        faults = race_f;
        permanent_faulty_alu_i = faults;
      end
      #1;
      if (!stall_o) break;
      n++;
    end
    pipe_empty_i = 1'b1;
  endtask

  // Present new faults and return the detect-cycle stall plus the count.
  task automatic apply_faults(input int hold, output logic det, output int n);
    @(posedge clock_gated); #1;
    alu_en_i = 1'b0;
    permanent_faulty_alu_i = faults;
    #1;
    det = stall_o;
    count_stall(hold, 0, faults, n);
  endtask

  task automatic test_reset;
    issue(ALU_ADD);
    checks++; if (alu_en_o !== 4'b0111) $display("FAIL reset_en: got %b want 0111", alu_en_o); else passed++;
    checks++; if (vote_mode_o !== 2'd0) $display("FAIL reset_vote: got %0d want 0", vote_mode_o); else passed++;
    checks++; if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_o); else passed++;
    checks++; if (cnt_clk_en_o !== 4'hF) $display("FAIL reset_cnt: got %h want f", cnt_clk_en_o); else passed++;
    checks++; if (fatal_o !== 1'b0) $display("FAIL reset_fatal: got %b want 0", fatal_o); else passed++;
  endtask

  task automatic test_single_fault;
    logic det; int n;
    faults[1][0] = 1'b1;
    apply_faults(0, det, n);
    checks++; if (det !== 1'b1) $display("FAIL single_detect_stall: got %b want 1", det); else passed++;
    checks++; if (n != 11) $display("FAIL single_stall_len: got %0d want 11", n); else passed++;
    issue(ALU_ADD);
    checks++; if (alu_en_o !== 4'b1101) $display("FAIL single_add_en: got %b want 1101", alu_en_o); else passed++;
    checks++; if (vote_mode_o !== 2'd0) $display("FAIL single_add_vote: got %0d want 0", vote_mode_o); else passed++;
    issue(ALU_XOR);
    checks++; if (alu_en_o !== 4'b0111) $display("FAIL single_xor_en: got %b want 0111", alu_en_o); else passed++;
    checks++; if (cnt_clk_en_o !== 4'hF) $display("FAIL single_cnt: got %h want f", cnt_clk_en_o); else passed++;
  endtask

  task automatic test_dmr_single;
    logic det; int n;
    faults[0][1] = 1'b1;
    faults[2][1] = 1'b1;
    apply_faults(0, det, n);
    checks++; if (n != 11) $display("FAIL dmr_stall_len: got %0d want 11", n); else passed++;
    issue(ALU_OR);
    checks++; if (alu_en_o !== 4'b1010) $display("FAIL dmr_or_en: got %b want 1010", alu_en_o); else passed++;
    checks++; if (vote_mode_o !== 2'd1) $display("FAIL dmr_or_vote: got %0d want 1", vote_mode_o); else passed++;
    faults[3][1] = 1'b1;
    apply_faults(0, det, n);
    issue(ALU_OR);
    checks++; if (alu_en_o !== 4'b0010) $display("FAIL single_or_en: got %b want 0010", alu_en_o); else passed++;
    checks++; if (vote_mode_o !== 2'd2) $display("FAIL single_or_vote: got %0d want 2", vote_mode_o); else passed++;
  endtask

  task automatic test_drain_hold;
    logic det; int n;
    faults[0][2] = 1'b1;
    // 5 cycles not empty, 1 drain-exit cycle, 9 rebuild, 1 settle.
    apply_faults(5, det, n);
    checks++; if (det !== 1'b1) $display("FAIL drain_detect_stall: got %b want 1", det); else passed++;
    checks++; if (n != 16) $display("FAIL drain_stall_len: got %0d want 16", n); else passed++;
    issue(ALU_BSET);
    checks++; if (alu_en_o !== 4'b1110) $display("FAIL drain_bset_en: got %b want 1110", alu_en_o); else passed++;
    checks++; if (vote_mode_o !== 2'd0) $display("FAIL drain_bset_vote: got %0d want 0", vote_mode_o); else passed++;
  endtask

  task automatic test_rebuild_race;
    logic [3:0][8:0] late;
    logic det; int n;
    faults[0][6] = 1'b1;
    late = faults;
    late[2][8] = 1'b1;
    @(posedge clock_gated); #1;
    alu_en_i = 1'b0;
    permanent_faulty_alu_i = faults;
    #1;
    det = stall_o;
    // k=1 drain, k=5 is the 4th rebuild cycle; then a full second pass.
    count_stall(0, 5, late, n);
    checks++; if (n != 22) $display("FAIL race_stall_len: got %0d want 22", n); else passed++;
    issue(ALU_DIV);
    checks++; if (alu_en_o !== 4'b1011) $display("FAIL race_div_en: got %b want 1011", alu_en_o); else passed++;
    checks++; if (vote_mode_o !== 2'd0) $display("FAIL race_div_vote: got %0d want 0", vote_mode_o); else passed++;
    issue(ALU_ABS);
    checks++; if (alu_en_o !== 4'b1110) $display("FAIL race_abs_en: got %b want 1110", alu_en_o); else passed++;
  endtask

  task automatic test_clk_en;
    logic det; int n;
    for (int c = 0; c < 9; c++) faults[3][c] = 1'b1;
    apply_faults(0, det, n);
    checks++; if (n != 11) $display("FAIL clken_stall_len: got %0d want 11", n); else passed++;
    issue(ALU_ADD);
    checks++; if (alu_en_o !== 4'b0101) $display("FAIL clken_add_en: got %b want 0101", alu_en_o); else passed++;
    checks++; if (vote_mode_o !== 2'd1) $display("FAIL clken_add_vote: got %0d want 1", vote_mode_o); else passed++;
    checks++; if (cnt_clk_en_o !== 4'b0111) $display("FAIL clken_cnt: got %b want 0111", cnt_clk_en_o); else passed++;
    issue(7'h7F);
    checks++; if (alu_en_o !== 4'b0000) $display("FAIL clken_noclass_en: got %b want 0000", alu_en_o); else passed++;
  endtask

  task automatic test_fatal;
    logic det; int n;
    for (int a = 0; a < 4; a++) faults[a][5] = 1'b1;
    apply_faults(0, det, n);
    checks++; if (fatal_o !== 1'b1) $display("FAIL fatal_set: got %b want 1", fatal_o); else passed++;
    issue(ALU_EQ);
    checks++; if (alu_en_o !== 4'b0000) $display("FAIL fatal_eq_en: got %b want 0000", alu_en_o); else passed++;
    checks++; if (vote_mode_o !== 2'd3) $display("FAIL fatal_eq_vote: got %0d want 3", vote_mode_o); else passed++;
    @(posedge clock_gated); #1;
    rst_n = 1'b0;
    @(posedge clock_gated); #1;
    rst_n = 1'b1;
    #1;
    checks++; if (fatal_o !== 1'b0) $display("FAIL rst_fatal: got %b want 0", fatal_o); else passed++;
    checks++; if (vote_mode_o !== 2'd0) $display("FAIL rst_eq_vote: got %0d want 0", vote_mode_o); else passed++;
    checks++; if (alu_en_o !== 4'b0000) $display("FAIL rst_eq_en: got %b want 0000", alu_en_o); else passed++;
    checks++; if (stall_o !== 1'b1) $display("FAIL rst_redetect: got %b want 1", stall_o); else passed++;
    checks++; if (cnt_clk_en_o !== 4'hF) $display("FAIL rst_cnt: got %h want f", cnt_clk_en_o); else passed++;
    alu_en_i = 1'b0;
    count_stall(0, 0, faults, n);
    checks++; if (n != 11) $display("FAIL rst_rebuild_len: got %0d want 11", n); else passed++;
    checks++; if (fatal_o !== 1'b1) $display("FAIL rst_fatal_again: got %b want 1", fatal_o); else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    faults = '0;
    permanent_faulty_alu_i = '0;
    alu_en_i = 1'b0;
    alu_operator_i = ALU_ADD;
    pipe_empty_i = 1'b1;
    repeat (2) @(posedge clock_gated);
    #1 rst_n = 1'b1;
    test_reset();
    test_single_fault();
    test_dmr_single();
    test_drain_hold();
    test_rebuild_race();
    test_clk_en();
    test_fatal();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
